stream_wrr_arbiter: RTL and testbench
=====================================

# stream_wrr_arbiter

Weighted round-robin arbiter that merges `NumInp` valid/ready streams onto one output stream. It sits in front of a shared downstream resource, such as a decoded memory port or a demuxed stream sink. Each input may hold the output for up to `weight` consecutive transfers per turn. The output is lock-stable: once offered, a beat never changes until it is accepted.

## Interface
- `NumInp`, 4: number of input streams, ≥2.
- `WeightWidth`, 4: bits per weight entry.
- `DATA_T`, `logic [31:0]`: payload type.
- `IdxWidth`, `$clog2(NumInp)`: derived, do not override.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active low.
- `flush_i`  in  1  synchronous clear of the round-robin state.
- `weight_i`  in  NumInp×WeightWidth  per-input burst weight; 0 is treated as 1.
- `inp_data_i`  in  NumInp×DATA_T  input payloads.
- `inp_valid_i`  in  NumInp  input valids.
- `inp_ready_o`  out  NumInp  input readies.
- `oup_data_o`  out  DATA_T  selected payload.
- `oup_valid_o`  out  1  output valid.
- `oup_ready_i`  in  1  output ready.
- `idx_o`  out  IdxWidth  index of the selected input.

## Operation
- Registers:
  - `ptr_q`: priority pointer, an input index.
  - `cnt_q`: transfers granted to `ptr_q` in the current turn, WeightWidth bits.
  - `lock_q`: lock flag.
  - `lock_idx_q`: locked input index.
- Selection `sel`:
  - If `lock_q`, `sel = lock_idx_q`.
  - Otherwise `sel` is the first index `i` with `inp_valid_i[i]=1`, scanning `ptr_q, ptr_q+1, …` modulo NumInp.
  - If no input is valid, `sel = ptr_q`.
- Output path:
  - `oup_valid_o = inp_valid_i[sel]`.
  - `oup_data_o = inp_data_i[sel]`.
  - `idx_o = sel`.
  - `inp_ready_o[i] = oup_ready_i & (i==sel)`; all other readies are 0.
- Handshake (`oup_valid_o & oup_ready_i`):
  - `w = max(weight_i[sel],1)`, sampled in the handshake cycle.
  - `n = (sel==ptr_q) ? cnt_q+1 : 1`.
  - If `n ≥ w`: `ptr_q ← (sel+1) mod NumInp`, `cnt_q ← 0`.
  - Else: `ptr_q ← sel`, `cnt_q ← n`.
  - `lock_q ← 0`.
- Stall (`oup_valid_o & ~oup_ready_i`): `lock_q ← 1`, `lock_idx_q ← sel`. `ptr_q` and `cnt_q` hold.
- Idle cycle (no handshake, no stall): all state holds.
  - An owner that stops requesting forfeits the rest of its burst, because the scan skips it.
  - The next granted input starts a fresh turn with `n=1`.
- `flush_i` (no handshake in that cycle): `ptr_q ← 0`, `cnt_q ← 0`. `lock_q` and `lock_idx_q` are unaffected, so a pending beat stays stable.
- `flush_i` together with a handshake: the flush wins for `ptr_q`/`cnt_q`, and `lock_q` clears.
- Assertions (simulation only):
  - A locked input whose valid drops before handshake is a protocol violation.
  - Locked data changing before handshake is a protocol violation.
  - `NumInp < 2` is rejected at elaboration.

## Timing
- Reset values: `ptr_q=0`, `cnt_q=0`, `lock_q=0`, `lock_idx_q=0`.
- Outputs are combinational. With all inputs idle:
  - `oup_valid_o=0`, `inp_ready_o=0`, `idx_o=0`.
  - `oup_data_o = inp_data_i[0]`.
- Latency is zero cycles from input to output. There are combinational paths valid→valid, data→data and ready→ready.
- No combinational path exists from `oup_ready_i` to `oup_valid_o`.
- Throughput is one beat per cycle, back-to-back, including switches between inputs.
- Async reset mid-lock clears the lock immediately. Selection restarts from index 0.
- The weight is consumed per beat. A weight change takes effect at the next handshake.
- `cnt_q` never exceeds `2^WeightWidth−2`.

## Test plan
- **Reset/idle:**
  - Stimulus: assert `rst_ni=0`, then release with all valids 0.
  - Required: `oup_valid_o=0`, `inp_ready_o=4'b0000`, `idx_o=0`.
- **Equal weights:**
  - Stimulus: weights {1,1,1,1}, all inputs valid, `oup_ready_i=1` for 8 cycles.
  - Required: `idx_o` = 0,1,2,3,0,1,2,3.
- **Weighted, including weight 0:**
  - Stimulus: weights {3,1,2,0}, all inputs valid, `oup_ready_i=1` for 10 cycles.
  - Required: `idx_o` = 0,0,0,1,2,2,3,0,0,0.
- **Lock stability:**
  - Setup: weights all 1; after one beat from input 0, `ptr_q=1`.
  - Stimulus: only input 2 valid, `oup_ready_i=0` for 3 cycles; input 1 raises valid during the stall.
  - Required: `idx_o=2` with unchanged data for all 3 stall cycles.
  - Then raise `oup_ready_i`. Required: the beat from input 2 transfers, then `idx_o=3` if input 3 is valid, else 1.
- **Burst forfeit:**
  - Stimulus: weight[0]=4, only input 0 valid for 2 beats, then input 0 drops and input 1 is valid.
  - Required: input 1 granted immediately.
  - Stimulus: input 0 revalidates. Required: it is served only after the pointer wraps past inputs 1–3.
- **Flush mid-burst:**
  - Stimulus: weight[2]=4, pulse `flush_i` after 2 beats from input 2, with inputs 0 and 2 valid.
  - Required: next grant `idx_o=0`; input 2 then gets a fresh count of 4.

Source files
------------

// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin merge of NumInp valid/ready streams onto one output stream.
// Latency: zero cycles, the selected input is routed combinationally to the output.
// Backpressure: a stalled beat is locked until accepted; ready goes only to the selected input.
module stream_wrr_arbiter #(
    parameter int unsigned NumInp      = 4,
    parameter int unsigned WeightWidth = 4,
    parameter type         DATA_T      = logic [31:0],
    localparam int unsigned IdxWidth   = $clog2(NumInp)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic [NumInp-1:0][WeightWidth-1:0]  weight_i,
    input  DATA_T [NumInp-1:0]                  inp_data_i,
    input  logic [NumInp-1:0]                   inp_valid_i,
    output logic [NumInp-1:0]                   inp_ready_o,
    output DATA_T                               oup_data_o,
    output logic                                oup_valid_o,
    input  logic                                oup_ready_i,
    output logic [IdxWidth-1:0]                 idx_o
);

    if (NumInp < 2) begin : g_num_inp_check
        $error("stream_wrr_arbiter: NumInp must be at least 2");
    end

    logic [IdxWidth-1:0]    ptr_q;
    logic [IdxWidth-1:0]    lock_idx_q;
    logic [WeightWidth-1:0] cnt_q;
    logic                   lock_q;

    logic [IdxWidth-1:0]    sel;
    logic [IdxWidth-1:0]    sel_inc;
    logic [WeightWidth-1:0] w;
    logic [WeightWidth:0]   n;
    logic                   found;
    logic                   hs;
    logic                   stall;
    logic                   turn_done;

    // Index arithmetic modulo NumInp, valid for any NumInp (not only powers of two).
    function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] base,
                                                     input int unsigned off);
        int unsigned s;
        s = {{(32-IdxWidth){1'b0}}, base} + off;
        if (s >= NumInp) s = s - NumInp;
        return s[IdxWidth-1:0];
    endfunction

    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < NumInp; k++) begin
                if (!found && inp_valid_i[wrap_add(ptr_q, k)]) begin
                    sel   = wrap_add(ptr_q, k);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        oup_valid_o = inp_valid_i[sel];
        oup_data_o  = inp_data_i[sel];
        idx_o       = sel;
        inp_ready_o = '0;
        inp_ready_o[sel] = oup_ready_i;
    end

    // Burst accounting: a beat from anyone other than the pointer owner starts a new turn.
    always_comb begin
        hs        = oup_valid_o & oup_ready_i;
        stall     = oup_valid_o & ~oup_ready_i;
        w         = (weight_i[sel] == '0) ? WeightWidth'(1) : weight_i[sel];
        n         = (sel == ptr_q) ? ({1'b0, cnt_q} + (WeightWidth+1)'(1)) : (WeightWidth+1)'(1);
        turn_done = (n >= {1'b0, w});
        sel_inc   = wrap_add(sel, 32'd1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (flush_i) begin
                ptr_q <= '0;
                cnt_q <= '0;
            end else if (hs) begin
                if (turn_done) begin
                    ptr_q <= sel_inc;
                    cnt_q <= '0;
                end else begin
                    ptr_q <= sel;
                    cnt_q <= n[WeightWidth-1:0];
                end
            end
            if (hs) begin
                lock_q <= 1'b0;
            end else if (stall) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
        end
    end

`ifndef SYNTHESIS
    // A locked beat must stay offered, with identical payload, until it is accepted.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> inp_valid_i[lock_idx_q])
        else $error("stream_wrr_arbiter: locked input dropped valid before handshake");

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> (inp_data_i[lock_idx_q] == $past(oup_data_o)))
        else $error("stream_wrr_arbiter: locked data changed before handshake");
`endif

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Bench for stream_wrr_arbiter: directed scenarios with literal grant orders, then random
// traffic checked every cycle against a turn-based model of the arbitration rules.
module tb_stream_wrr_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [N-1:0][3:0]  weight = '0;
    logic [N-1:0][31:0] data = '0;
    logic [N-1:0]     valid = '0;
    logic [N-1:0]     inp_ready;
    logic [31:0]      oup_data;
    logic             oup_valid;
    logic             oup_ready = 1'b0;
    logic [1:0]       idx;

    stream_wrr_arbiter #(.NumInp(N), .WeightWidth(4), .DATA_T(logic [31:0])) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .weight_i   (weight),
        .inp_data_i (data),
        .inp_valid_i(valid),
        .inp_ready_o(inp_ready),
        .oup_data_o (oup_data),
        .oup_valid_o(oup_valid),
        .oup_ready_i(oup_ready),
        .idx_o      (idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int grants[$];
    logic [N-1:0] acc = '0;
    logic [N-1:0] took = '0;
    int unsigned seqn = 1;

    // Model: who owns the current turn, how many beats it has used, and any held offer.
    int turn_owner = 0;
    int turn_beats = 0;
    bit hold       = 1'b0;
    int hold_idx   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_sel();
        if (hold) return hold_idx;
        for (int k = 0; k < N; k++) begin
            if (valid[(turn_owner + k) % N]) return (turn_owner + k) % N;
        end
        return turn_owner;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_owner = 0;
            turn_beats = 0;
            hold       = 1'b0;
            hold_idx   = 0;
        end else begin
            int s;
            int w;
            int used;
            s = exp_sel();
            if (valid[s] && oup_ready) begin
                w    = (weight[s] == 0) ? 1 : int'(weight[s]);
                used = (s == turn_owner) ? turn_beats + 1 : 1;
                if (used >= w) begin
                    turn_owner = (s + 1) % N;
                    turn_beats = 0;
                end else begin
                    turn_owner = s;
                    turn_beats = used;
                end
                hold = 1'b0;
            end else if (valid[s]) begin
                hold     = 1'b1;
                hold_idx = s;
            end
            if (flush) begin
                turn_owner = 0;
                turn_beats = 0;
            end
        end
    end

    always @(negedge clk) begin
        int s;
        logic [N-1:0] exp_rdy;
        s = exp_sel();
        exp_rdy = '0;
        if (oup_ready) exp_rdy[s] = 1'b1;
        check("oup_valid", 64'(oup_valid), 64'(valid[s]));
        check("idx", 64'(idx), 64'(s));
        check("inp_ready", 64'(inp_ready), 64'(exp_rdy));
        check("oup_data", 64'(oup_data), 64'(data[s]));
        acc = valid & inp_ready;
        if (oup_valid && oup_ready) grants.push_back(int'(idx));
    end

    task automatic fresh(input int i);
        data[i] = {i[7:0], seqn[23:0]};
        seqn++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        took = acc;
        #1;
        for (int i = 0; i < N; i++) if (took[i]) fresh(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        oup_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_grants(input string name, input int exp[$]);
        check({name, "_count"}, 64'(grants.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < grants.size(); k++)
            check(name, 64'(grants[k]), 64'(exp[k]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        logic [31:0] d_locked;
        for (int i = 0; i < N; i++) fresh(i);
        @(posedge clk);
        #1;

        // Reset / idle
        do_reset();
        @(negedge clk);
        check("idle_valid", 64'(oup_valid), 64'd0);
        check("idle_ready", 64'(inp_ready), 64'd0);
        check("idle_idx", 64'(idx), 64'd0);
        check("idle_data", 64'(oup_data), 64'(data[0]));
        @(posedge clk);
        #1;

        // Equal weights
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        valid = 4'b1111;
        oup_ready = 1'b1;
        grants.delete();
        repeat (8) next_cycle();
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_grants("equal_w", exp_q);

        // Weighted with a zero weight
        do_reset();
        weight = {4'd0, 4'd2, 4'd1, 4'd3};
        valid = 4'b1111;
        oup_ready = 1'b1;
        grants.delete();
        repeat (10) next_cycle();
        exp_q = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        check_grants("weighted", exp_q);

        // Lock stability
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        valid = 4'b0001;
        oup_ready = 1'b1;
        next_cycle();
        valid = 4'b0100;
        oup_ready = 1'b0;
        d_locked = data[2];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lock_idx", 64'(idx), 64'd2);
            check("lock_data", 64'(oup_data), 64'(d_locked));
            check("lock_ready", 64'(inp_ready), 64'd0);
            next_cycle();
            valid[1] = 1'b1;
        end
        oup_ready = 1'b1;
        grants.delete();
        @(negedge clk);
        check("lock_release_data", 64'(oup_data), 64'(d_locked));
        next_cycle();
        next_cycle();
        exp_q = '{2, 1};
        check_grants("lock_release", exp_q);

        // Burst forfeit
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd4};
        oup_ready = 1'b1;
        grants.delete();
        valid = 4'b0001;
        repeat (2) next_cycle();
        valid = 4'b0010;
        next_cycle();
        valid = 4'b1111;
        repeat (7) next_cycle();
        exp_q = '{0, 0, 1, 2, 3, 0, 0, 0, 0, 1};
        check_grants("forfeit", exp_q);

        // Flush mid-burst, coinciding with a handshake
        do_reset();
        weight = {4'd1, 4'd4, 4'd1, 4'd1};
        oup_ready = 1'b1;
        grants.delete();
        valid = 4'b0100;
        repeat (2) next_cycle();
        valid = 4'b0101;
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        repeat (6) next_cycle();
        exp_q = '{2, 2, 2, 0, 2, 2, 2, 2, 0};
        check_grants("flush", exp_q);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < N; i++) weight[i] = 4'($urandom_range(0, 15));
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (!valid[i] || took[i]) begin
                    valid[i] = ($urandom_range(0, 2) != 0);
                    fresh(i);
                end
            end
            oup_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) weight[$urandom_range(0, N-1)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
        end
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
